// File: rtl/mm_arbiter_pkg.sv
// Shared types and idle-bus constants for the memory-mapped round-robin arbiter.
package mm_arb_pkg;

   // Two-state controller: pick a master, then carry its transfer to the slave.
   typedef enum logic {
      ARB  = 1'b0,
      XFER = 1'b1
   } arb_state_t;

   // Values placed on the slave port whenever no transfer is in flight.
   localparam int unsigned IDLE_ADDR  = 32'd0;
   localparam int unsigned IDLE_WDATA = 32'd0;

endpackage

// File: rtl/mm_arbiter_if.sv
// Bundle of master-side and slave-side bus signals around the arbiter.
// slave modport: the arbiter's view (it serves the requesting masters).
// master modport: the environment's view (requesting masters plus the memory slave).
interface mm_arbiter_if #(
   parameter int N  = 32'd4,
   parameter int AW = 32'd8,
   parameter int DW = 32'd8
);
   logic [N-1:0]    m_req;
   logic [N-1:0]    m_write;
   logic [N-1:0]    m_read;
   logic [N*AW-1:0] m_address;
   logic [N*DW-1:0] m_writedata;
   logic [N-1:0]    m_grant;
   logic [N-1:0]    m_ack;
   logic [N-1:0]    m_err;
   logic [DW-1:0]   m_readdata;
   logic [AW-1:0]   s_address;
   logic            s_write;
   logic            s_read;
   logic [DW-1:0]   s_writedata;
   logic [DW-1:0]   s_readdata;
   logic            s_waitrequest;

   modport slave (
      input  m_req, m_write, m_read, m_address, m_writedata,
      input  s_readdata, s_waitrequest,
      output m_grant, m_ack, m_err, m_readdata,
      output s_address, s_write, s_read, s_writedata
   );

   modport master (
      output m_req, m_write, m_read, m_address, m_writedata,
      output s_readdata, s_waitrequest,
      input  m_grant, m_ack, m_err, m_readdata,
      input  s_address, s_write, s_read, s_writedata
   );

endinterface

// File: rtl/mm_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after 'last' in wrap order.
module rr_pick #(
   parameter int N = 32'd4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] last,
   output logic                 valid,
   output logic [$clog2(N)-1:0] idx,
   output logic [N-1:0]         onehot
);

   localparam int LW = $clog2(N);

   int            sum_s;
   logic [LW-1:0] cand_s;

   // Walk last+1 .. last+N (mod N) and latch the first requester found.
   always_comb begin
      valid  = 1'b0;
      idx    = '0;
      onehot = '0;
      sum_s  = 32'sd0;
      cand_s = '0;
      for (int i = 1; i <= N; i++) begin
         sum_s = int'(last) + i;
         if (sum_s >= N) begin
            cand_s = LW'(sum_s - N);
         end else begin
            cand_s = LW'(sum_s);
         end
         if (!valid && req[cand_s]) begin
            valid          = 1'b1;
            idx            = cand_s;
            onehot[cand_s] = 1'b1;
         end else begin
            valid = valid;
         end
      end
   end

endmodule

// File: rtl/mm_arbiter.sv
// Round-robin arbiter sharing one memory-mapped slave between N masters,
// with per-transfer stall timeout and request-withdrawal handling.
module mm_arbiter
   import mm_arb_pkg::*;
#(
   parameter int N       = 32'd4,
   parameter int AW      = 32'd8,
   parameter int DW      = 32'd8,
   parameter int TIMEOUT = 32'd255
) (
   input  logic          CLK,
   input  logic          reset,
   mm_arbiter_if.slave   bus
);

   localparam int         LW      = $clog2(N);
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   arb_state_t    state_r;
   logic [N-1:0]  grant_r;
   logic [LW-1:0] gidx_r;
   logic [LW-1:0] last_r;
   logic [7:0]    wait_cnt_r;

   logic          pick_valid_s;
   logic [LW-1:0] pick_idx_s;
   logic [N-1:0]  pick_onehot_s;

   logic          xfer_s;
   logic          g_req_s;
   logic          g_wr_s;
   logic          g_rd_s;
   logic [AW-1:0] g_addr_s;
   logic [DW-1:0] g_wdata_s;
   logic          done_s;
   logic          abort_s;

   rr_pick #(.N(N)) u_pick (
      .req    (bus.m_req),
      .last   (last_r),
      .valid  (pick_valid_s),
      .idx    (pick_idx_s),
      .onehot (pick_onehot_s)
   );

   // Decode the granted master's request and classify this cycle as done, abort or stall.
   always_comb begin
      xfer_s    = (state_r == XFER) && !reset;
      g_req_s   = bus.m_req[gidx_r];
      g_wr_s    = bus.m_write[gidx_r];
      g_rd_s    = bus.m_read[gidx_r] & ~g_wr_s;
      g_addr_s  = bus.m_address[int'(gidx_r)*AW +: AW];
      g_wdata_s = bus.m_writedata[int'(gidx_r)*DW +: DW];
      done_s    = xfer_s & g_req_s & (g_wr_s | g_rd_s) & ~bus.s_waitrequest;
      abort_s   = xfer_s & g_req_s & ~done_s & (wait_cnt_r == TO_LAST);
   end

   // Route the granted master onto the slave port and build ack/err/readdata.
   always_comb begin
      bus.s_address   = AW'(IDLE_ADDR);
      bus.s_writedata = DW'(IDLE_WDATA);
      bus.s_write     = 1'b0;
      bus.s_read      = 1'b0;
      if (xfer_s) begin
         bus.s_address   = g_addr_s;
         bus.s_writedata = g_wdata_s;
         bus.s_write     = g_req_s & g_wr_s & ~abort_s;
         bus.s_read      = g_req_s & g_rd_s & ~abort_s;
      end else begin
         bus.s_write     = 1'b0;
      end
      bus.m_grant    = grant_r;
      bus.m_ack      = done_s  ? grant_r : '0;
      bus.m_err      = abort_s ? grant_r : '0;
      bus.m_readdata = (done_s && g_rd_s) ? bus.s_readdata : '0;
   end

   // Controller: arbitrate in ARB, track stall count and exit conditions in XFER.
   always_ff @(posedge CLK) begin
      if (reset) begin
         state_r    <= ARB;
         grant_r    <= '0;
         gidx_r     <= '0;
         last_r     <= LW'(N - 1);
         wait_cnt_r <= 8'd0;
      end else begin
         case (state_r)
            ARB: begin
               if (pick_valid_s) begin
                  grant_r    <= pick_onehot_s;
                  gidx_r     <= pick_idx_s;
                  wait_cnt_r <= 8'd0;
                  state_r    <= XFER;
               end else begin
                  grant_r    <= '0;
               end
            end
            XFER: begin
               if (!g_req_s) begin
                  grant_r <= '0;
                  state_r <= ARB;
               end else if (done_s || abort_s) begin
                  last_r  <= gidx_r;
                  grant_r <= '0;
                  state_r <= ARB;
               end else begin
                  wait_cnt_r <= wait_cnt_r + 8'd1;
               end
            end
            default: begin
               grant_r <= '0;
               state_r <= ARB;
            end
         endcase
      end
   end

endmodule
